mcdt_rx_demux: RTL and testbench



---
 rtl/mcdt_rx_pkg.sv | 9 +
 rtl/mcdt_rx_fifo.sv | 51 +++++
 rtl/mcdt_rx_demux.sv | 111 +++++++++++
 tb/tb_mcdt_rx_demux.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mcdt_rx_pkg.sv
// Shared constants and types for the mcdt receive-side demultiplexer.
package mcdt_rx_pkg;
  localparam int DATA_W = 32;
  localparam int CH_NUM = 3;
  localparam logic [1:0] ID_ILLEGAL = 2'd3;
  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  typedef logic [1:0] ch_id_t;
endpackage

// File: rtl/mcdt_rx_fifo.sv
// Show-ahead FIFO: head is visible one cycle after a push into an empty FIFO, 0 when empty.
// Accepts a push when full only if the same cycle pops; otherwise the push is refused.
module mcdt_rx_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic             full,
  output logic             accept,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop_ok;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop_ok = pop & ~empty;
  // A full FIFO always has a head, so a concurrent pop frees the slot this push needs.
  assign accept = push & (~full | pop_ok);
  assign dout   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mcdt_rx_demux.sv
// Demuxes the mcdt stream into three show-ahead FIFOs (1-cycle latency); the input has no
// backpressure, so full-channel and id==3 words are dropped and flagged. MCDT_RX_SEQ_CHECK_EN adds seq_err_o.
module mcdt_rx_demux
  import mcdt_rx_pkg::*;
#(
  parameter int DATA_W     = mcdt_rx_pkg::DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] mcdt_data_i,
  input  logic              mcdt_val_i,
  input  logic [1:0]        mcdt_id_i,
  output logic [DATA_W-1:0] rx0_data_o,
  output logic              rx0_valid_o,
  input  logic              rx0_ready_i,
  output logic [CNT_W-1:0]  rx0_count_o,
  output logic [DATA_W-1:0] rx1_data_o,
  output logic              rx1_valid_o,
  input  logic              rx1_ready_i,
  output logic [CNT_W-1:0]  rx1_count_o,
  output logic [DATA_W-1:0] rx2_data_o,
  output logic              rx2_valid_o,
  input  logic              rx2_ready_i,
  output logic [CNT_W-1:0]  rx2_count_o,
  output logic [2:0]        ovf_o,
  output logic              err_id_o,
  output logic [7:0]        drop_cnt_o
`ifdef MCDT_RX_SEQ_CHECK_EN
  ,
  output logic [2:0]        seq_err_o
`endif
);
  logic [DATA_W-1:0] head [CH_NUM];
  logic [CNT_W-1:0]  cnt  [CH_NUM];
  logic [CH_NUM-1:0] push, pop, full, empty, accept, ovf_now;
  logic              bad_id;

  assign pop = {rx2_ready_i, rx1_ready_i, rx0_ready_i};

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    assign push[n] = mcdt_val_i && (mcdt_id_i == ch_id_t'(n));

    mcdt_rx_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk    (clk_i),
      .rst    (rst_i),
      .push   (push[n]),
      .pop    (pop[n]),
      .din    (mcdt_data_i),
      .dout   (head[n]),
      .empty  (empty[n]),
      .full   (full[n]),
      .accept (accept[n]),
      .count  (cnt[n])
    );
  end

  assign rx0_data_o  = head[0];
  assign rx1_data_o  = head[1];
  assign rx2_data_o  = head[2];
  assign rx0_valid_o = ~empty[0];
  assign rx1_valid_o = ~empty[1];
  assign rx2_valid_o = ~empty[2];
  assign rx0_count_o = cnt[0];
  assign rx1_count_o = cnt[1];
  assign rx2_count_o = cnt[2];

  // At most one word arrives per cycle, so drop_cnt_o never needs more than +1.
  assign ovf_now = push & full & ~pop;
  assign bad_id  = mcdt_val_i && (mcdt_id_i == ID_ILLEGAL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_o      <= '0;
      err_id_o   <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      ovf_o <= ovf_o | ovf_now;
      if (bad_id) err_id_o <= 1'b1;
      if ((bad_id || (|ovf_now)) && (drop_cnt_o != DROP_CNT_MAX))
        drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

`ifdef MCDT_RX_SEQ_CHECK_EN
  logic [DATA_W-1:0] exp_q [CH_NUM];
  logic [CH_NUM-1:0] seen_q;

  // Expectation follows the last word actually stored; refused words leave it untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seen_q    <= '0;
      seq_err_o <= '0;
      for (int n = 0; n < CH_NUM; n++) exp_q[n] <= '0;
    end else begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (accept[n]) begin
          if (seen_q[n] && (mcdt_data_i != exp_q[n])) seq_err_o[n] <= 1'b1;
          exp_q[n]  <= mcdt_data_i + DATA_W'(1);
          seen_q[n] <= 1'b1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_mcdt_rx_demux.sv
// Directed bench for mcdt_rx_demux: reset, latency, overflow, full+pop, interleaving, bad id.
module tb_mcdt_rx_demux;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        val;
  logic [1:0]  id;
  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [31:0] dat [3];
  logic [3:0]  cnt [3];
  logic [2:0]  ovf;
  logic        err_id;
  logic [7:0]  drop;
`ifdef MCDT_RX_SEQ_CHECK_EN
  logic [2:0]  seq_err;
`endif

  int errors = 0;
  int checks = 0;
  int got [3];

  always #5 clk = ~clk;

  mcdt_rx_demux dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mcdt_data_i (data),
    .mcdt_val_i  (val),
    .mcdt_id_i   (id),
    .rx0_data_o  (dat[0]),
    .rx0_valid_o (vld[0]),
    .rx0_ready_i (rdy[0]),
    .rx0_count_o (cnt[0]),
    .rx1_data_o  (dat[1]),
    .rx1_valid_o (vld[1]),
    .rx1_ready_i (rdy[1]),
    .rx1_count_o (cnt[1]),
    .rx2_data_o  (dat[2]),
    .rx2_valid_o (vld[2]),
    .rx2_ready_i (rdy[2]),
    .rx2_count_o (cnt[2]),
    .ovf_o       (ovf),
    .err_id_o    (err_id),
    .drop_cnt_o  (drop)
`ifdef MCDT_RX_SEQ_CHECK_EN
    ,
    .seq_err_o   (seq_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] ch, input logic [31:0] w);
    val  = 1'b1;
    id   = ch;
    data = w;
    tick();
    val  = 1'b0;
  endtask

  // Pops happen at the next edge when valid and ready are both high now.
  task automatic score_pops();
    for (int k = 0; k < 3; k++) begin
      if (vld[k] && rdy[k]) begin
        chk("rr_data", dat[k], 32'h00C0_0000 | (32'(k) << 16) | 32'(got[k]));
        got[k]++;
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    val  = 1'b0;
    id   = 2'd0;
    data = '0;
    rdy  = 3'b000;
    #1;

    // 1: reset held during traffic
    val  = 1'b1;
    data = 32'hDEAD_BEEF;
    repeat (5) tick();
    chk("rst_vld", 32'(vld), 0);
    chk("rst_cnt0", 32'(cnt[0]), 0);
    chk("rst_dat0", dat[0], 0);
    rst = 1'b0;
    val = 1'b0;
    tick();
    chk("post_rst_vld", 32'(vld), 0);
    chk("post_rst_ovf", 32'(ovf), 0);
    chk("post_rst_err", 32'(err_id), 0);
    chk("post_rst_drop", 32'(drop), 0);

    // 2: single word on ch0, consumer ready throughout
    rdy[0] = 1'b1;
    send(2'd0, 32'h00C0_0000);
    chk("single_vld", 32'(vld[0]), 1);
    chk("single_dat", dat[0], 32'h00C0_0000);
    chk("single_cnt", 32'(cnt[0]), 1);
    tick();
    chk("single_vld_after", 32'(vld[0]), 0);
    chk("single_cnt_after", 32'(cnt[0]), 0);
    chk("single_dat_after", dat[0], 0);

    // 3: overflow on ch1
    rdy[1] = 1'b0;
    for (int i = 0; i < 10; i++) send(2'd1, 32'h00C1_0000 + 32'(i));
    chk("ovf_cnt", 32'(cnt[1]), 8);
    chk("ovf_flag", 32'(ovf), 3'b010);
    chk("ovf_drop", 32'(drop), 2);
    rdy[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", dat[1], 32'h00C1_0000 + 32'(i));
      tick();
    end
    chk("ovf_drained_vld", 32'(vld[1]), 0);
    chk("ovf_drained_cnt", 32'(cnt[1]), 0);

    // 4: push into full ch2 with concurrent pop
    rdy[2] = 1'b0;
    for (int i = 0; i < 8; i++) send(2'd2, 32'h00C2_0000 + 32'(i));
    chk("full_cnt", 32'(cnt[2]), 8);
    rdy[2] = 1'b1;
    send(2'd2, 32'h00C2_0008);
    chk("fullpop_cnt", 32'(cnt[2]), 8);
    chk("fullpop_ovf", 32'(ovf), 3'b010);
    chk("fullpop_drop", 32'(drop), 2);
    for (int i = 1; i <= 8; i++) begin
      chk("fullpop_order", dat[2], 32'h00C2_0000 + 32'(i));
      tick();
    end
    chk("fullpop_empty", 32'(cnt[2]), 0);

    // 5: round-robin traffic with random ready; reset clears sticky state first
    rdy = 3'b000;
    do_reset();
    chk("rr_rst_ovf", 32'(ovf), 0);
    chk("rr_rst_drop", 32'(drop), 0);
    for (int k = 0; k < 3; k++) got[k] = 0;
    for (int c = 0; c < 300; c++) begin
      val  = 1'b1;
      id   = 2'(c % 3);
      data = 32'h00C0_0000 | (32'(c % 3) << 16) | 32'(c / 3);
      for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(0, 3) != 0);
      score_pops();
      tick();
    end
    val = 1'b0;
    rdy = 3'b111;
    repeat (20) begin
      score_pops();
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk("rr_total", 32'(got[k]), 100);
      chk("rr_cnt_end", 32'(cnt[k]), 0);
    end
    chk("rr_drop", 32'(drop), 0);
    chk("rr_ovf", 32'(ovf), 0);

    // 6: illegal id
    send(2'd3, 32'h1234_5678);
    chk("badid_err", 32'(err_id), 1);
    chk("badid_vld", 32'(vld), 0);
    chk("badid_drop", 32'(drop), 1);
    tick();
    chk("badid_sticky", 32'(err_id), 1);

    // with val low, id and data are ignored
    id   = 2'd3;
    data = 32'hFFFF_FFFF;
    tick();
    chk("idle_drop", 32'(drop), 1);
    chk("idle_vld", 32'(vld), 0);

`ifdef MCDT_RX_SEQ_CHECK_EN
    do_reset();
    send(2'd0, 32'd5);
    send(2'd0, 32'd6);
    chk("seq_ok", 32'(seq_err), 0);
    send(2'd0, 32'd8);
    chk("seq_err", 32'(seq_err), 3'b001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
